// File: rtl/tmr_ctrl_pkg.sv
// tmr_ctrl_pkg: shared FSM encoding and helpers for the TMR fault controller
package tmr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESYNC = 2'd2, HALT = 2'd3} state_e;
  localparam int LANES = 3;
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/tmr_lane_monitor.sv
// tmr_lane_monitor: per-lane mismatch streak counter with sticky bad flag
module tmr_lane_monitor #(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic fault_i,
  input  logic clr_i,
  output logic bad_o,
  output logic newly_bad_o
);
  localparam int SW = $clog2(THRESH + 1);
  localparam logic [SW-1:0] SAT = SW'(THRESH);
  logic [SW-1:0] streak_q, streak_d;
  logic bad_q, bad_d, reach;
  // Streak only survives while sampling, so leaving RUN flushes it.
  always_comb begin
    reach       = sample_en_i & fault_i & (streak_q == SAT - SW'(1));
    streak_d    = (clr_i | ~sample_en_i | ~fault_i) ? '0 :
                  (streak_q == SAT) ? SAT : streak_q + SW'(1);
    bad_d       = ~clr_i & (bad_q | reach);
    newly_bad_o = reach & ~bad_q & ~clr_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      streak_q <= streak_d;
      bad_q    <= bad_d;
    end
  end
  assign bad_o = bad_q;
endmodule

// File: rtl/tmr_fault_ctrl.sv
// tmr_fault_ctrl: supervises a triplicated counter, scheduling resyncs and halting
// when majority voting is no longer trustworthy
module tmr_fault_ctrl
  import tmr_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int THRESH     = 4,
  parameter int RESYNC_CYC = 2,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [2:0]       fault_vec_i,
  input  logic             no_majority_i,
  input  logic             clr_status_i,
  output logic             cnt_enable_o,
  output logic             resync_o,
  output logic [2:0]       lane_bad_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic             alarm_o,
  output logic [1:0]       state_o
);
  localparam int RW = $clog2(RESYNC_CYC + 1);
  if (WIDTH < 1 || THRESH < 1 || RESYNC_CYC < 1 || ERR_W < 1) begin : g_bad_param
    $error("tmr_fault_ctrl: illegal parameter value");
  end
  state_e           state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             alarm_q, alarm_d, en_q, rs_q;
  logic [2:0]       bad, newly;
  logic             run;
  assign run = (state_q == RUN);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tmr_lane_monitor #(.THRESH(THRESH)) u_mon (
      .clk        (clk),
      .rst        (rst),
      .sample_en_i(run),
      .fault_i    (fault_vec_i[i]),
      .clr_i      (clr_status_i),
      .bad_o      (bad[i]),
      .newly_bad_o(newly[i])
    );
  end
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE:   state_d = (start_i & ~stop_i) ? RUN : IDLE;
      RUN: begin
        if (no_majority_i || popcount3(bad | newly) >= 2'd2) state_d = HALT;
        else if (|newly) begin
          state_d = RESYNC;
          rcnt_d  = RW'(RESYNC_CYC - 1);
        end else if (stop_i) state_d = IDLE;
      end
      RESYNC: begin
        if (rcnt_q == '0) state_d = stop_i ? IDLE : RUN;
        else rcnt_d = rcnt_q - RW'(1);
      end
      HALT:   state_d = clr_status_i ? IDLE : HALT;
      default: state_d = IDLE;
    endcase
    err_d   = clr_status_i ? '0 : (run & |fault_vec_i & ~&err_q) ? err_q + ERR_W'(1) : err_q;
    alarm_d = ~clr_status_i & (alarm_q | (run & state_d == HALT));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      err_q   <= '0;
      alarm_q <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      alarm_q <= alarm_d;
      en_q    <= (state_d == RUN);
      rs_q    <= (state_d == RESYNC);
    end
  end
  assign cnt_enable_o = en_q;
  assign resync_o     = rs_q;
  assign lane_bad_o   = bad;
  assign err_count_o  = err_q;
  assign alarm_o      = alarm_q;
  assign state_o      = state_q;
endmodule
